// File: rtl/reg_file_sb.sv
// Register file with per-register outstanding-write scoreboard.
// Combinational reads with writeback bypass; stall on RAW hazards and counter overflow.
module reg_file_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int R0_ZERO = 1,
  parameter int CNT_W   = 2
) (
  input  logic                  clk_rf,
  input  logic                  rst_rf_n,
  input  logic [ADDR_W-1:0]     sr_addr,
  input  logic [ADDR_W-1:0]     tr_addr,
  output logic [DATA_W-1:0]     sr_data_0,
  output logic [DATA_W-1:0]     tr_data_0,
  input  logic                  issue_valid,
  input  logic                  issue_writes,
  input  logic [ADDR_W-1:0]     issue_dr_addr,
  output logic                  stall,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic [2**ADDR_W-1:0]  busy,
  output logic                  wb_err
);
  localparam int NREGS = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [NREGS-1:0][DATA_W-1:0] r_regs;
  logic [NREGS-1:0][CNT_W-1:0]  r_cnt;
  logic [NREGS-1:0][CNT_W-1:0]  w_cnt_nxt;
  logic [NREGS-1:0]             w_pend;
  logic [NREGS-1:0]             w_busy_nxt;
  logic                         w_byp, w_ovf, w_accept, w_err_set;

  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return (R0_ZERO != 0) && (a == '0);
  endfunction

  // Bypass is suppressed while in reset so reads return 0 there.
  assign w_byp = wb_en && rst_rf_n;

  assign sr_data_0 = is_r0(sr_addr) ? '0
                   : (w_byp && wb_addr == sr_addr) ? wb_data : r_regs[sr_addr];
  assign tr_data_0 = is_r0(tr_addr) ? '0
                   : (w_byp && wb_addr == tr_addr) ? wb_data : r_regs[tr_addr];

  // A full counter only refuses the issue when no writeback retires one this cycle.
  assign w_ovf    = issue_writes && (r_cnt[issue_dr_addr] == CMAX)
                 && !(wb_en && wb_addr == issue_dr_addr);
  assign stall    = issue_valid && (w_pend[sr_addr] || w_pend[tr_addr] || w_ovf);
  assign w_accept = issue_valid && !stall && issue_writes && !is_r0(issue_dr_addr);
  assign w_err_set = wb_en && (r_cnt[wb_addr] == '0) && !is_r0(wb_addr);

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    localparam logic [ADDR_W-1:0] A = ADDR_W'(g);
    logic w_hit_wb, w_inc, w_dec;
    assign w_hit_wb  = wb_en && (wb_addr == A);
    assign w_inc     = w_accept && (issue_dr_addr == A);
    assign w_dec     = w_hit_wb && (r_cnt[g] != '0);
    // The last outstanding write resolving this cycle is covered by bypass.
    assign w_pend[g] = !is_r0(A) && (r_cnt[g] != '0)
                    && !(w_hit_wb && r_cnt[g] == CNT_W'(1));
    assign w_cnt_nxt[g] = (w_inc && !w_dec) ? r_cnt[g] + CNT_W'(1)
                        : (w_dec && !w_inc) ? r_cnt[g] - CNT_W'(1) : r_cnt[g];
    assign w_busy_nxt[g] = (w_cnt_nxt[g] != '0);
  end

  always_ff @(posedge clk_rf or negedge rst_rf_n) begin
    if (!rst_rf_n) begin
      r_regs <= '0;
      r_cnt  <= '0;
      busy   <= '0;
      wb_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      busy  <= w_busy_nxt;
      if (wb_en && !is_r0(wb_addr)) r_regs[wb_addr] <= wb_data;
      if (w_err_set) wb_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed table-driven bench for reg_file_sb: reads, bypass, RAW/overflow stall,
// r0 handling, wb_err and asynchronous reset mid-stall.
module tb_reg_file_sb;
  logic        gclk = 1'b0;
  logic        grst_n;
  logic [2:0]  sr_addr, tr_addr, issue_dr_addr, wb_addr;
  logic [15:0] sr_data_0, tr_data_0, wb_data;
  logic        issue_valid, issue_writes, stall, wb_en, wb_err;
  logic [7:0]  busy;

  int checks = 0;
  int errors = 0;

  always #5 gclk = ~gclk;

  reg_file_sb dut (
    .clk_rf(gclk), .rst_rf_n(grst_n),
    .sr_addr(sr_addr), .tr_addr(tr_addr),
    .sr_data_0(sr_data_0), .tr_data_0(tr_data_0),
    .issue_valid(issue_valid), .issue_writes(issue_writes),
    .issue_dr_addr(issue_dr_addr), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .wb_err(wb_err)
  );

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  s, t;
    logic        iv, iw;
    logic [2:0]  d;
    logic [15:0] e_sr, e_tr;
    logic        e_stall;
    logic [7:0]  e_busy;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                              input logic [2:0] s, input logic [2:0] t,
                              input logic iv, input logic iw, input logic [2:0] d,
                              input logic [15:0] es, input logic [15:0] et, input logic est,
                              input logic [7:0] eb, input logic ee);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.s = s; v.t = t; v.iv = iv; v.iw = iw; v.d = d;
    v.e_sr = es; v.e_tr = et; v.e_stall = est; v.e_busy = eb; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [2:0] s, input logic [2:0] t,
                       input logic iv, input logic iw, input logic [2:0] d);
    wb_en = we; wb_addr = wa; wb_data = wd; sr_addr = s; tr_addr = t;
    issue_valid = iv; issue_writes = iw; issue_dr_addr = d;
  endtask

  initial begin
    grst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // write/bypass preceded by an issue so r3 has an outstanding write
    vecs.push_back(mk(0,0,16'h0000, 0,0, 1,1,3, 16'h0000,16'h0000,0, 8'h08,0));
    vecs.push_back(mk(1,3,16'hBEEF, 3,3, 0,0,0, 16'hBEEF,16'hBEEF,0, 8'h00,0));
    vecs.push_back(mk(0,0,16'h0000, 3,0, 0,0,0, 16'hBEEF,16'h0000,0, 8'h00,0));
    // RAW on r5
    vecs.push_back(mk(0,0,16'h0000, 3,3, 1,1,5, 16'hBEEF,16'hBEEF,0, 8'h20,0));
    vecs.push_back(mk(0,0,16'h0000, 0,5, 1,0,0, 16'h0000,16'h0000,1, 8'h20,0));
    vecs.push_back(mk(1,5,16'h0042, 0,5, 1,0,0, 16'h0000,16'h0042,0, 8'h00,0));
    // overflow on r2 (max 3 outstanding)
    vecs.push_back(mk(0,0,16'h0000, 5,0, 1,1,2, 16'h0042,16'h0000,0, 8'h04,0));
    vecs.push_back(mk(0,0,16'h0000, 0,0, 1,1,2, 16'h0000,16'h0000,0, 8'h04,0));
    vecs.push_back(mk(0,0,16'h0000, 0,0, 1,1,2, 16'h0000,16'h0000,0, 8'h04,0));
    vecs.push_back(mk(0,0,16'h0000, 0,0, 1,1,2, 16'h0000,16'h0000,1, 8'h04,0));
    vecs.push_back(mk(1,2,16'h1234, 0,0, 1,1,2, 16'h0000,16'h0000,0, 8'h04,0));
    // drain: exactly three writebacks must clear r2
    vecs.push_back(mk(1,2,16'h1111, 2,0, 0,0,0, 16'h1111,16'h0000,0, 8'h04,0));
    vecs.push_back(mk(1,2,16'h2222, 2,0, 0,0,0, 16'h2222,16'h0000,0, 8'h04,0));
    vecs.push_back(mk(1,2,16'h3333, 2,0, 1,0,0, 16'h3333,16'h0000,0, 8'h00,0));
    vecs.push_back(mk(0,0,16'h0000, 2,0, 1,0,0, 16'h3333,16'h0000,0, 8'h00,0));
    // r0 ignores writes and is never tracked
    vecs.push_back(mk(1,0,16'hFFFF, 0,0, 0,0,0, 16'h0000,16'h0000,0, 8'h00,0));
    vecs.push_back(mk(0,0,16'h0000, 0,3, 0,0,0, 16'h0000,16'hBEEF,0, 8'h00,0));
    vecs.push_back(mk(0,0,16'h0000, 0,0, 1,1,0, 16'h0000,16'h0000,0, 8'h00,0));
    vecs.push_back(mk(0,0,16'h0000, 0,0, 1,1,0, 16'h0000,16'h0000,0, 8'h00,0));
    // unexpected writeback to r6 flags wb_err but still writes
    vecs.push_back(mk(1,6,16'h6666, 6,0, 0,0,0, 16'h6666,16'h0000,0, 8'h00,1));
    vecs.push_back(mk(0,0,16'h0000, 6,2, 0,0,0, 16'h6666,16'h3333,0, 8'h00,1));

    // reset state
    repeat (3) @(posedge gclk);
    #1 chk("rst_busy_in", busy, 8'h00);
    @(negedge gclk) grst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      @(negedge gclk);
      sr_addr = a[2:0]; tr_addr = 3'(7 - a);
      #1;
      chk($sformatf("rst_sr%0d", a), sr_data_0, 16'h0000);
      chk($sformatf("rst_tr%0d", a), tr_data_0, 16'h0000);
    end
    chk("rst_busy", busy, 8'h00);
    chk("rst_err", wb_err, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge gclk);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].s, vecs[i].t,
            vecs[i].iv, vecs[i].iw, vecs[i].d);
      #1;
      chk($sformatf("v%0d_sr", i), sr_data_0, vecs[i].e_sr);
      chk($sformatf("v%0d_tr", i), tr_data_0, vecs[i].e_tr);
      chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
      @(posedge gclk); #1;
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_err", i), wb_err, vecs[i].e_err);
    end

    // async reset in the middle of a stall
    @(negedge gclk) drive(0, 0, 0, 0, 0, 1, 1, 4);
    @(posedge gclk); #1 chk("ar_busy_set", busy, 8'h10);
    @(negedge gclk) drive(0, 0, 0, 4, 6, 1, 0, 0);
    #1 chk("ar_stall_pre", stall, 1'b1);
    grst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 8'h00);
    chk("ar_stall", stall, 1'b0);
    chk("ar_err", wb_err, 1'b0);
    chk("ar_tr6", tr_data_0, 16'h0000);
    wb_en = 1'b1; wb_addr = 3'd6; wb_data = 16'hABCD;
    #1 chk("ar_nobyp", tr_data_0, 16'h0000);
    @(negedge gclk);
    drive(0, 0, 0, 2, 6, 1, 0, 0);
    grst_n = 1'b1;
    #1;
    chk("ar_r2", sr_data_0, 16'h0000);
    chk("ar_stall_post", stall, 1'b0);
    @(posedge gclk); #1 chk("ar_busy_post", busy, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
